uart_frame_deserializer: RTL

//  Parametrised UART RX frame deserializer: collects mid-bit samples after a start-bit detection,

---
 rtl/uart_frame_deserializer_pkg.sv | 13 +
 rtl/uart_parity_check.sv | 13 +
 rtl/uart_frame_deserializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_deserializer_pkg.sv
// Shared definitions for the UART RX frame deserializer: FSM state encodings and default width.
package uart_frame_deserializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/uart_parity_check.sv
// Combinational parity checker: flags a mismatch between the received parity bit and the data word.
module uart_parity_check #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic [WIDTH-1:0] data,
  input  logic             parity_bit,
  output logic             err
);

  assign err = (^{data, parity_bit}) != ODD;

endmodule

// File: rtl/uart_frame_deserializer.sv
// UART RX frame deserializer: assembles data bits from mid-bit samples, checks parity/stop bits,
// and holds the received word on a valid/ready output register.
//
//   state     | meaning
//   ST_IDLE   | waiting for frame_start_in
//   ST_DATA   | shifting in DATA_WIDTH data bits
//   ST_PARITY | waiting for the parity bit sample
//   ST_STOP   | checking STOP_BITS stop samples, commit on the last one
module uart_frame_deserializer
  import uart_frame_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start_in,
  input  logic                  bit_valid_in,
  input  logic                  sampled_bit_in,
  input  logic                  frame_abort_in,
  input  logic                  data_ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  parity_err_out,
  output logic                  stop_err_out,
  output logic                  overrun_out,
  output logic                  busy_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    stop_cnt;
  logic                    parity_err_acc;
  logic                    stop_err_acc;

  logic                    parity_calc_err;
  logic                    last_stop;
  logic                    stop_err_final;
  logic                    start_frame;
  logic                    accept;

  uart_parity_check #(
    .WIDTH (DATA_WIDTH),
    .ODD   (PARITY_ODD != 0)
  ) u_parity_check (
    .data       (shift_reg),
    .parity_bit (sampled_bit_in),
    .err        (parity_calc_err)
  );

  always_comb begin
    last_stop      = (state == ST_STOP) && bit_valid_in && !frame_abort_in &&
                     ((STOP_BITS == 1) || stop_cnt);
    stop_err_final = stop_err_acc | ~sampled_bit_in;
    // A start pulse coinciding with the final stop strobe chains straight into the next frame.
    start_frame    = frame_start_in && !frame_abort_in && ((state == ST_IDLE) || last_stop);
    accept         = data_valid_out && data_ready_in;
  end

  assign busy_out = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      stop_cnt       <= 1'b0;
      parity_err_acc <= 1'b0;
      stop_err_acc   <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      parity_err_out <= 1'b0;
      stop_err_out   <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      overrun_out <= 1'b0;

      // Commit into a full, unaccepted output register drops the new frame.
      if (last_stop) begin
        if (data_valid_out && !data_ready_in) begin
          overrun_out <= 1'b1;
        end else begin
          data_out       <= shift_reg;
          parity_err_out <= parity_err_acc;
          stop_err_out   <= stop_err_final;
          data_valid_out <= 1'b1;
        end
      end else if (accept) begin
        data_out       <= '0;
        parity_err_out <= 1'b0;
        stop_err_out   <= 1'b0;
        data_valid_out <= 1'b0;
      end

      if (frame_abort_in) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_DATA: begin
            if (bit_valid_in) begin
              if (LSB_FIRST != 0) begin
                shift_reg <= {sampled_bit_in, shift_reg[DATA_WIDTH-1:1]};
              end else begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], sampled_bit_in};
              end
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                stop_cnt <= 1'b0;
              end
            end
          end
          ST_PARITY: begin
            if (bit_valid_in) begin
              parity_err_acc <= parity_calc_err;
              state          <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (bit_valid_in) begin
              stop_err_acc <= stop_err_final;
              stop_cnt     <= 1'b1;
              if (last_stop) begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (start_frame) begin
          state          <= ST_DATA;
          bit_cnt        <= '0;
          shift_reg      <= '0;
          stop_cnt       <= 1'b0;
          parity_err_acc <= 1'b0;
          stop_err_acc   <= 1'b0;
        end
      end
    end
  end

endmodule
